audio_frame_sched: RTL and testbench

//  Sequences the sample FIFO (fifo_m) between the audio ADC and the LPC analysis core.

---
 rtl/audio_frame_sched.sv | 137 +++++++++++++
 tb/tb_audio_frame_sched.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_sched.sv
// Frame scheduler between the ADC sample FIFO and the LPC analysis core.
// Write side pushes samples into the FIFO and drops them (sticky o_ovf) when it is full.
// Read side waits until a whole frame is buffered, then streams it with valid/ready.
// The FIFO only exports full/empty, so the buffered-sample count is tracked here.
module audio_frame_sched #(
  parameter int unsigned B         = 8,
  parameter int unsigned W         = 2,
  parameter int unsigned FRAME_LEN = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_enable,
  input  logic         i_smp_valid,
  input  logic [B-1:0] i_smp_data,
  input  logic         i_fifo_full,
  input  logic         i_fifo_empty,
  input  logic [B-1:0] i_fifo_r_data,
  output logic         o_fifo_wr,
  output logic         o_fifo_rd,
  output logic [B-1:0] o_fifo_w_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [B-1:0] o_out_data,
  output logic         o_out_first,
  output logic         o_out_last,
  output logic [W:0]   o_level,
  output logic [15:0]  o_frame_cnt,
  output logic         o_ovf,
  input  logic         i_ovf_clr
);

  localparam int unsigned IdxW     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(FRAME_LEN - 1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);
  localparam logic [W:0] LvlOne   = (W + 1)'(1);
  localparam logic [W:0] LvlMax   = (W + 1)'(2 ** W);
  localparam logic [W:0] LvlFrame = (W + 1)'(FRAME_LEN);

  typedef enum logic [1:0] {StIdle, StFill, StStream} state_e;

  state_e          r_state;
  logic [IdxW-1:0] r_idx;
  logic [W:0]      r_level;
  logic [15:0]     r_frame_cnt;
  logic            r_ovf;

  logic w_wr;
  logic w_rd;
  logic w_drop;
  logic w_valid;
  logic w_first;
  logic w_last;

  // Handshake and FIFO strobes, decoded from the current state and the FIFO flags.
  always_comb begin
    // A full FIFO never takes a write, even when it is being popped in the same cycle.
    w_wr    = ~reset & i_enable & i_smp_valid & ~i_fifo_full;
    w_drop  = i_enable & i_smp_valid & i_fifo_full;
    w_valid = (r_state == StStream) & ~i_fifo_empty;
    w_rd    = w_valid & i_out_ready;
    w_first = w_valid & (r_idx == '0);
    w_last  = w_valid & (r_idx == IdxLast);
  end

  assign o_fifo_wr     = w_wr;
  assign o_fifo_rd     = w_rd;
  assign o_fifo_w_data = i_smp_data;
  assign o_out_valid   = w_valid;
  assign o_out_data    = i_fifo_r_data;
  assign o_out_first   = w_first;
  assign o_out_last    = w_last;
  assign o_level       = r_level;
  assign o_frame_cnt   = r_frame_cnt;
  assign o_ovf         = r_ovf;

  // Occupancy mirror of the FIFO; the guards only matter if the flags and count ever disagree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level <= '0;
    end else begin
      case ({w_wr, w_rd})
        2'b10:   if (r_level != LvlMax) r_level <= r_level + LvlOne;
        2'b01:   if (r_level != '0)     r_level <= r_level - LvlOne;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle wins over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (i_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // Frame sequencer: wait for a full frame, stream it, count it, then wait again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_enable) r_state <= StFill;
        end
        StFill: begin
          // Uses the registered level, which is what gives the one-cycle bubble between frames.
          if (r_level >= LvlFrame) begin
            r_state <= StStream;
            r_idx   <= '0;
          end else if (!i_enable) begin
            r_state <= StIdle;
          end
        end
        StStream: begin
          // Dropping enable here does not abort; the frame runs to its last sample.
          if (w_rd) begin
            if (r_idx == IdxLast) begin
              r_idx       <= '0;
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_state     <= i_enable ? StFill : StIdle;
            end else begin
              r_idx <= r_idx + IdxOne;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_frame_sched.sv
// Bench for audio_frame_sched: a small behavioural FIFO plus a queue-based reference model.
module tb_audio_frame_sched;

  localparam int unsigned B     = 8;
  localparam int unsigned W     = 2;
  localparam int unsigned FL    = 4;
  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         en, sv, rdy, clr;
  logic [B-1:0] sd;

  logic         fifo_full, fifo_empty;
  logic [B-1:0] fifo_r_data;
  logic         o_fifo_wr, o_fifo_rd, o_out_valid, o_out_first, o_out_last, o_ovf;
  logic [B-1:0] o_fifo_w_data, o_out_data;
  logic [W:0]   o_level;
  logic [15:0]  o_frame_cnt;

  always #5 clk = ~clk;

  audio_frame_sched #(.B(B), .W(W), .FRAME_LEN(FL)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_enable     (en),
    .i_smp_valid  (sv),
    .i_smp_data   (sd),
    .i_fifo_full  (fifo_full),
    .i_fifo_empty (fifo_empty),
    .i_fifo_r_data(fifo_r_data),
    .o_fifo_wr    (o_fifo_wr),
    .o_fifo_rd    (o_fifo_rd),
    .o_fifo_w_data(o_fifo_w_data),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (rdy),
    .o_out_data   (o_out_data),
    .o_out_first  (o_out_first),
    .o_out_last   (o_out_last),
    .o_level      (o_level),
    .o_frame_cnt  (o_frame_cnt),
    .o_ovf        (o_ovf),
    .i_ovf_clr    (clr)
  );

  // Behavioural FIFO: ignores a write while full, even with a simultaneous read.
  logic [B-1:0] f_mem [DEPTH];
  logic [1:0]   f_wp, f_rp;
  logic [2:0]   f_cnt;
  logic         f_do_w, f_do_r;
  assign fifo_full   = (f_cnt == 3'd4);
  assign fifo_empty  = (f_cnt == 3'd0);
  assign fifo_r_data = f_mem[f_rp];
  assign f_do_w      = o_fifo_wr & ~fifo_full;
  assign f_do_r      = o_fifo_rd & ~fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_wp  <= 2'd0;
      f_rp  <= 2'd0;
      f_cnt <= 3'd0;
    end else begin
      if (f_do_w) begin
        f_mem[f_wp] <= o_fifo_w_data;
        f_wp        <= f_wp + 2'd1;
      end
      if (f_do_r) f_rp <= f_rp + 2'd1;
      case ({f_do_w, f_do_r})
        2'b10:   f_cnt <= f_cnt + 3'd1;
        2'b01:   f_cnt <= f_cnt - 3'd1;
        default: f_cnt <= f_cnt;
      endcase
    end
  end

  // Reference model: buffered samples, mode (0 idle, 1 fill, 2 stream), frame position.
  logic [B-1:0] m_q [$];
  int           m_mode, m_pos, m_frames;
  logic         m_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [B-1:0] t1_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  task automatic model_reset();
    m_q.delete();
    m_mode   = 0;
    m_pos    = 0;
    m_frames = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input logic s, input logic [B-1:0] d, input logic r,
                       input logic c);
    en  = e;
    sv  = s;
    sd  = d;
    rdy = r;
    clr = c;
    #1;
  endtask

  // Compare every output against the model, clock once, advance the model.
  task automatic tick();
    int   lvl;
    logic acc, drop, valid, hs, first, last;
    lvl   = m_q.size();
    acc   = en && sv && (lvl < DEPTH);
    drop  = en && sv && (lvl >= DEPTH);
    valid = (m_mode == 2) && (lvl > 0);
    hs    = valid && rdy;
    first = valid && (m_pos == 0);
    last  = valid && (m_pos == FL - 1);
    check("fifo_wr", 32'(o_fifo_wr), 32'(acc));
    check("fifo_w_data", 32'(o_fifo_w_data), 32'(sd));
    check("out_valid", 32'(o_out_valid), 32'(valid));
    check("fifo_rd", 32'(o_fifo_rd), 32'(hs));
    check("out_first", 32'(o_out_first), 32'(first));
    check("out_last", 32'(o_out_last), 32'(last));
    check("level", 32'(o_level), 32'(lvl));
    check("frame_cnt", 32'(o_frame_cnt), 32'(m_frames % 65536));
    check("ovf", 32'(o_ovf), 32'(m_ovf));
    if (valid) check("out_data", 32'(o_out_data), 32'(m_q[0]));
    if (m_mode == 2) check("stream_nonempty", 32'(fifo_empty), 32'd0);
    @(posedge clk);
    if (hs) void'(m_q.pop_front());
    if (acc) m_q.push_back(sd);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    case (m_mode)
      0: if (en) m_mode = 1;
      1: begin
        if (lvl >= FL) begin
          m_mode = 2;
          m_pos  = 0;
        end else if (!en) begin
          m_mode = 0;
        end
      end
      default: begin
        if (hs) begin
          if (m_pos == FL - 1) begin
            m_pos = 0;
            m_frames++;
            m_mode = en ? 1 : 0;
          end else begin
            m_pos++;
          end
        end
      end
    endcase
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(o_out_valid), 32'd0);
    check({tag, "_first"}, 32'(o_out_first), 32'd0);
    check({tag, "_last"}, 32'(o_out_last), 32'd0);
    check({tag, "_rd"}, 32'(o_fifo_rd), 32'd0);
    check({tag, "_wr"}, 32'(o_fifo_wr), 32'd0);
    check({tag, "_level"}, 32'(o_level), 32'd0);
    check({tag, "_frame_cnt"}, 32'(o_frame_cnt), 32'd0);
    check({tag, "_ovf"}, 32'(o_ovf), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1);
  end

  initial begin
    int nf, nl, cyc;
    reset = 1'b1;
    en = 0; sv = 0; sd = '0; rdy = 0; clr = 0;
    model_reset();
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Test 1: four samples, then one frame streamed with ready held high.
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, t1_exp[k], 1, 0);
      tick();
      check("t1_level_fill", 32'(o_level), 32'(k + 1));
    end
    drive(1, 0, 8'h00, 1, 0);
    check("t1_valid_gap", 32'(o_out_valid), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 8'h00, 1, 0);
      check("t1_valid", 32'(o_out_valid), 32'd1);
      check("t1_data", 32'(o_out_data), 32'(t1_exp[k]));
      check("t1_first", 32'(o_out_first), 32'(k == 0));
      check("t1_last", 32'(o_out_last), 32'(k == 3));
      tick();
    end
    check("t1_frames", 32'(o_frame_cnt), 32'd1);
    check("t1_level_end", 32'(o_level), 32'd0);

    // Test 2: backpressure for five cycles in the middle of a frame.
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 8'(8'hA0 + k), 0, 0);
      tick();
    end
    repeat (2) begin drive(1, 0, 8'h00, 0, 0); tick(); end
    repeat (2) begin drive(1, 0, 8'h00, 1, 0); tick(); end
    repeat (5) begin
      drive(1, 0, 8'h00, 0, 0);
      check("t2_hold_valid", 32'(o_out_valid), 32'd1);
      check("t2_hold_data", 32'(o_out_data), 32'h0000_00A2);
      check("t2_hold_rd", 32'(o_fifo_rd), 32'd0);
      tick();
    end
    repeat (2) begin drive(1, 0, 8'h00, 1, 0); tick(); end
    check("t2_frames", 32'(o_frame_cnt), 32'd2);
    check("t2_level", 32'(o_level), 32'd0);

    // Test 3: overflow with the core stalled, then clear versus a same-cycle drop.
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 8'(8'hB0 + k), 0, 0);
      tick();
    end
    check("t3_level", 32'(o_level), 32'd4);
    check("t3_ovf", 32'(o_ovf), 32'd1);
    drive(1, 0, 8'h00, 0, 1);
    tick();
    check("t3_ovf_clr", 32'(o_ovf), 32'd0);
    drive(1, 1, 8'hBF, 0, 1);
    tick();
    check("t3_ovf_drop_wins", 32'(o_ovf), 32'd1);
    check("t3_level_hold", 32'(o_level), 32'd4);

    // Test 4: full FIFO, strobe and handshake together; the sample is dropped.
    drive(1, 1, 8'hCC, 1, 0);
    check("t4_wr", 32'(o_fifo_wr), 32'd0);
    check("t4_rd", 32'(o_fifo_rd), 32'd1);
    check("t4_data", 32'(o_out_data), 32'h0000_00B0);
    tick();
    check("t4_level", 32'(o_level), 32'd3);
    check("t4_ovf", 32'(o_ovf), 32'd1);
    drive(1, 0, 8'h00, 1, 1);
    tick();
    repeat (2) begin drive(1, 0, 8'h00, 1, 0); tick(); end
    check("t4_frames", 32'(o_frame_cnt), 32'd3);

    // Test 6a: enable drops after two samples of a frame; the frame still completes.
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 8'(8'hC0 + k), 0, 0);
      tick();
    end
    repeat (2) begin drive(1, 0, 8'h00, 0, 0); tick(); end
    repeat (2) begin drive(1, 0, 8'h00, 1, 0); tick(); end
    repeat (2) begin drive(0, 0, 8'h00, 1, 0); tick(); end
    check("t6_frames", 32'(o_frame_cnt), 32'd4);
    repeat (2) begin
      drive(0, 1, 8'hEE, 1, 0);
      check("t6_ignored_wr", 32'(o_fifo_wr), 32'd0);
      check("t6_idle_valid", 32'(o_out_valid), 32'd0);
      tick();
    end
    check("t6_level", 32'(o_level), 32'd0);
    check("t6_ovf", 32'(o_ovf), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      tick();
    end

    // Test 5: fresh start, strobes every cycle, eight frames.
    reset = 1'b1;
    drive(0, 0, 8'h00, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    nf  = 0;
    nl  = 0;
    cyc = 0;
    while (m_frames < 8 && cyc < 200) begin
      drive(1, 1, 8'($urandom), 1, 0);
      if (o_out_valid && o_out_first) nf++;
      if (o_out_valid && o_out_last) nl++;
      tick();
      cyc++;
    end
    check("t5_frames", 32'(o_frame_cnt), 32'd8);
    check("t5_first_count", 32'(nf), 32'd8);
    check("t5_last_count", 32'(nl), 32'd8);

    // Test 6b: reset asserted while a frame is being presented.
    drive(1, 1, 8'h5A, 0, 0);
    tick();
    cyc = 0;
    while (m_mode != 2 && cyc < 10) begin
      drive(1, 0, 8'h00, 0, 0);
      tick();
      cyc++;
    end
    drive(1, 0, 8'h00, 0, 0);
    check("t6b_pre_valid", 32'(o_out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("t6b_rst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (3) begin drive(0, 0, 8'h00, 1, 0); tick(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
